simcell_identifier: RTL

Sequential characteriser for the single-output combinational primitives in the simulation cell library. It works in the opposite direction to those cell models: a model maps inputs to Y, and this block observes Y and recovers which cell produced it. The block drives every input combination into one external cell under test and captures Y into a truth table. It then classifies that table against the library's known functions and reports a cell code. It sits in the gate-level self-check harness, beside the netlist under test.

---
 rtl/simcell_id_pkg.sv | 55 +++++
 rtl/simcell_tt_match.sv | 56 +++++
 rtl/simcell_identifier.sv | 92 +++++++++
 3 files changed

// File: rtl/simcell_id_pkg.sv
// Shared constants for the cell identifier: cell codes,
// per-arity truth tables, FSM encoding and settle bounds.
package simcell_id_pkg;

  localparam logic [4:0] CELL_UNKNOWN = 5'd0;
  localparam logic [4:0] CELL_BUF     = 5'd1;
  localparam logic [4:0] CELL_NOT     = 5'd2;
  localparam logic [4:0] CELL_AND     = 5'd3;
  localparam logic [4:0] CELL_NAND    = 5'd4;
  localparam logic [4:0] CELL_OR      = 5'd5;
  localparam logic [4:0] CELL_NOR     = 5'd6;
  localparam logic [4:0] CELL_XOR     = 5'd7;
  localparam logic [4:0] CELL_XNOR    = 5'd8;
  localparam logic [4:0] CELL_ANDNOT  = 5'd9;
  localparam logic [4:0] CELL_ORNOT   = 5'd10;
  localparam logic [4:0] CELL_MUX     = 5'd11;
  localparam logic [4:0] CELL_NMUX    = 5'd12;
  localparam logic [4:0] CELL_AOI3    = 5'd13;
  localparam logic [4:0] CELL_OAI3    = 5'd14;
  localparam logic [4:0] CELL_AOI4    = 5'd15;
  localparam logic [4:0] CELL_OAI4    = 5'd16;

  localparam logic [15:0] TT_BUF    = 16'h0002;
  localparam logic [15:0] TT_NOT    = 16'h0001;
  localparam logic [15:0] TT_AND    = 16'h0008;
  localparam logic [15:0] TT_NAND   = 16'h0007;
  localparam logic [15:0] TT_OR     = 16'h000E;
  localparam logic [15:0] TT_NOR    = 16'h0001;
  localparam logic [15:0] TT_XOR    = 16'h0006;
  localparam logic [15:0] TT_XNOR   = 16'h0009;
  localparam logic [15:0] TT_ANDNOT = 16'h0002;
  localparam logic [15:0] TT_ORNOT  = 16'h000B;
  localparam logic [15:0] TT_MUX    = 16'h00AC;
  localparam logic [15:0] TT_NMUX   = 16'h0053;
  localparam logic [15:0] TT_AOI3   = 16'h0007;
  localparam logic [15:0] TT_OAI3   = 16'h001F;
  localparam logic [15:0] TT_AOI4   = 16'h0777;
  localparam logic [15:0] TT_OAI4   = 16'h111F;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PROBE    = 2'd1;
  localparam logic [1:0] ST_CLASSIFY = 2'd2;
  localparam logic [1:0] ST_FINISH   = 2'd3;

  localparam int unsigned SETTLE_MIN = 1;
  localparam int unsigned SETTLE_MAX = 15;

  // Last probe index for a legal arity (1..4).
  function automatic logic [3:0] last_idx(
    input logic [2:0] n
  );
    return 4'((5'd1 << n) - 5'd1);
  endfunction

endpackage

// File: rtl/simcell_tt_match.sv
// Combinational lookup of a captured truth table
// against the library functions of a given arity.
module simcell_tt_match
  import simcell_id_pkg::*;
(
  input  logic [2:0]  nin,
  input  logic [15:0] tt,
  output logic [4:0]  code,
  output logic        match
);

  always_comb begin
    code = CELL_UNKNOWN;
    unique case (nin)
      3'd1: begin
        unique case (1'b1)
          tt[1:0] == TT_BUF[1:0]: code = CELL_BUF;
          tt[1:0] == TT_NOT[1:0]: code = CELL_NOT;
          default: ;
        endcase
      end
      3'd2: begin
        unique case (1'b1)
          tt[3:0] == TT_AND[3:0]:    code = CELL_AND;
          tt[3:0] == TT_NAND[3:0]:   code = CELL_NAND;
          tt[3:0] == TT_OR[3:0]:     code = CELL_OR;
          tt[3:0] == TT_NOR[3:0]:    code = CELL_NOR;
          tt[3:0] == TT_XOR[3:0]:    code = CELL_XOR;
          tt[3:0] == TT_XNOR[3:0]:   code = CELL_XNOR;
          tt[3:0] == TT_ANDNOT[3:0]: code = CELL_ANDNOT;
          tt[3:0] == TT_ORNOT[3:0]:  code = CELL_ORNOT;
          default: ;
        endcase
      end
      3'd3: begin
        unique case (1'b1)
          tt[7:0] == TT_MUX[7:0]:  code = CELL_MUX;
          tt[7:0] == TT_NMUX[7:0]: code = CELL_NMUX;
          tt[7:0] == TT_AOI3[7:0]: code = CELL_AOI3;
          tt[7:0] == TT_OAI3[7:0]: code = CELL_OAI3;
          default: ;
        endcase
      end
      3'd4: begin
        unique case (1'b1)
          tt == TT_AOI4: code = CELL_AOI4;
          tt == TT_OAI4: code = CELL_OAI4;
          default: ;
        endcase
      end
      default: ;
    endcase
    match = (code != CELL_UNKNOWN);
  end

endmodule

// File: rtl/simcell_identifier.sv
// Sweeps every input vector into an external cell, captures Y
// into a truth table and classifies it into a library cell code.
module simcell_identifier
  import simcell_id_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic        C,
  input  logic        R,
  input  logic        START,
  input  logic [2:0]  NIN,
  output logic [3:0]  PA,
  input  logic        PY,
  output logic        BUSY,
  output logic        DONE,
  output logic [15:0] TT,
  output logic [4:0]  CODE,
  output logic        MATCH,
  output logic        ERR
);

  localparam logic [3:0] SETTLE_W = 4'(SETTLE);

  logic [1:0] state;
  logic [2:0] nin;
  logic [3:0] cnt;
  logic [4:0] code_c;
  logic       match_c;
  logic       legal;
  logic       take;

  assign legal = (NIN >= 3'd1) && (NIN <= 3'd4);
  assign take  = START &&
                 (state == ST_IDLE ||
                  state == ST_FINISH);
  assign BUSY  = (state == ST_PROBE) ||
                 (state == ST_CLASSIFY);
  assign DONE  = (state == ST_FINISH);

  simcell_tt_match u_match (
    .nin   (nin),
    .tt    (TT),
    .code  (code_c),
    .match (match_c)
  );

  always_ff @(posedge C) begin
    if (R) begin
      state <= ST_IDLE;
      nin   <= '0;
      cnt   <= '0;
      PA    <= '0;
      TT    <= '0;
      CODE  <= '0;
      MATCH <= 1'b0;
      ERR   <= 1'b0;
    end else if (take) begin
      nin   <= NIN;
      cnt   <= '0;
      PA    <= '0;
      TT    <= '0;
      CODE  <= '0;
      MATCH <= 1'b0;
      ERR   <= !legal;
      state <= legal ? ST_PROBE : ST_FINISH;
    end else begin
      unique case (state)
        ST_PROBE: begin
          // PY only matters on the settle-terminal cycle
          if (cnt == SETTLE_W) begin
            TT[PA] <= PY;
            cnt    <= '0;
            if (PA == last_idx(nin))
              state <= ST_CLASSIFY;
            else
              PA <= PA + 4'd1;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        ST_CLASSIFY: begin
          CODE  <= code_c;
          MATCH <= match_c;
          state <= ST_FINISH;
        end
        ST_FINISH: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule
